// File: rtl/hir_stencil_pkg.sv
// rtl/hir_stencil_pkg.sv - shared constants and helpers for the 3x3 stencil
// Purpose: kernel shift weights, sum guard/normalisation widths and a clog2
// helper used to size the row/column counters and line-buffer addresses.
package hir_stencil_pkg;

  // Extra sum bits: the 1-2-1 kernel weights total 16, so four guard bits
  // make overflow impossible for any unsigned pixel value.
  localparam int SUM_GUARD_BITS = 4;

  // Kernel weights expressed as left-shift amounts (1, 2 and 4).
  localparam int W_CORNER = 0;
  localparam int W_EDGE   = 1;
  localparam int W_CENTRE = 2;

  // Divide by the kernel weight total (16).
  localparam int NORM_SHIFT = 4;

  // Bits needed to hold 0..n-1; never less than 1.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - one-row delay line with read-before-write access
// Purpose: holds one row of pixels; the entry at addr is read
// combinationally and overwritten on the same edge when we is high.
// Ports:
//   clk     - clock
//   we      - write enable (pixel accepted)
//   addr    - column index
//   wr_data - value stored at addr
//   rd_data - value held at addr before this edge's write
module line_buffer
  import hir_stencil_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 32,
  parameter int DEPTH         = 64
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(DEPTH)-1:0]   addr,
  input  logic [ELEMENT_WIDTH-1:0]  wr_data,
  output logic [ELEMENT_WIDTH-1:0]  rd_data
);

  logic [ELEMENT_WIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  // Contents are never reset; validity is tracked by the row/col counters.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wr_data;
  end

endmodule

// File: rtl/stencil3x3_avg.sv
// rtl/stencil3x3_avg.sv - streaming 3x3 Gaussian (1-2-1) weighted-average stencil
// Purpose: accepts one raster-order pixel per t pulse, keeps two line buffers
// and a 3x3 window, and emits the filtered value centred one row and one
// column behind each accepted pixel once a full window exists.
// Ports:
//   clk        - clock
//   rst        - asynchronous active-low reset (release synchronised)
//   t          - input valid
//   in_data    - pixel, raster order
//   out_valid  - out_data valid this cycle
//   out_data   - filtered pixel (0 while out_valid is low)
//   frame_done - pulse with the last output of a frame
//   busy       - high from first accepted pixel until frame_done, inclusive
module stencil3x3_avg
  import hir_stencil_pkg::*;
#(
  parameter int ELEMENT_WIDTH = 32,
  parameter int ROW_LEN       = 64,
  parameter int NUM_ROWS      = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      t,
  input  logic [ELEMENT_WIDTH-1:0]  in_data,
  output logic                      out_valid,
  output logic [ELEMENT_WIDTH-1:0]  out_data,
  output logic                      frame_done,
  output logic                      busy
);

  localparam int COL_W = clog2(ROW_LEN);
  localparam int ROW_W = clog2(NUM_ROWS);
  localparam int SUM_W = ELEMENT_WIDTH + SUM_GUARD_BITS;

  generate
    if (ROW_LEN < 3 || NUM_ROWS < 3) begin : g_bad_size
      $error("stencil3x3_avg: ROW_LEN and NUM_ROWS must both be at least 3");
    end
  endgenerate

  // Reset asserts immediately but releases only after two clean edges.
  logic [1:0] rst_sync_q;
  logic       rst_sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync_q <= '0;
    else      rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_sync = rst_sync_q[1];

  // Raster position of the pixel presented on in_data.
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_last;
  logic             row_last;

  assign col_last = (col == COL_W'(ROW_LEN - 1));
  assign row_last = (row == ROW_W'(NUM_ROWS - 1));

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      col <= '0;
      row <= '0;
    end else if (t) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

  // lb0 holds the previous row, lb1 the row before that.
  logic [ELEMENT_WIDTH-1:0] lb0_rd;
  logic [ELEMENT_WIDTH-1:0] lb1_rd;

  line_buffer #(.ELEMENT_WIDTH(ELEMENT_WIDTH), .DEPTH(ROW_LEN)) u_lb0 (
    .clk     (clk),
    .we      (t),
    .addr    (col),
    .wr_data (in_data),
    .rd_data (lb0_rd)
  );

  line_buffer #(.ELEMENT_WIDTH(ELEMENT_WIDTH), .DEPTH(ROW_LEN)) u_lb1 (
    .clk     (clk),
    .we      (t),
    .addr    (col),
    .wr_data (lb0_rd),
    .rd_data (lb1_rd)
  );

  // win[r][c]: r=0 is the oldest row, c=2 the newest column.
  logic [ELEMENT_WIDTH-1:0] win [3][3];

  always_ff @(posedge clk) begin
    if (t) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1_rd;
      win[1][2] <= lb0_rd;
      win[2][2] <= in_data;
    end
  end

  // Weighted row sums; they only matter when the matching valid bit is set.
  logic [SUM_W-1:0] rs_top;
  logic [SUM_W-1:0] rs_mid;
  logic [SUM_W-1:0] rs_bot;
  logic [SUM_W-1:0] total;

  always_ff @(posedge clk) begin
    rs_top <= (SUM_W'(win[0][0]) << W_CORNER) + (SUM_W'(win[0][1]) << W_EDGE)
            + (SUM_W'(win[0][2]) << W_CORNER);
    rs_mid <= (SUM_W'(win[1][0]) << W_EDGE) + (SUM_W'(win[1][1]) << W_CENTRE)
            + (SUM_W'(win[1][2]) << W_EDGE);
    rs_bot <= (SUM_W'(win[2][0]) << W_CORNER) + (SUM_W'(win[2][1]) << W_EDGE)
            + (SUM_W'(win[2][2]) << W_CORNER);
  end

  assign total = rs_top + rs_mid + rs_bot;

  // Valid/tag pipeline: stage 0 follows the window, stage 1 the row sums.
  logic v0, v1;
  logic tag0, tag1;

  always_ff @(posedge clk or negedge rst_sync) begin
    if (!rst_sync) begin
      v0         <= 1'b0;
      tag0       <= 1'b0;
      v1         <= 1'b0;
      tag1       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Windows straddling a row boundary (col<2) or the first two rows
      // are incomplete and never produce output.
      v0         <= t && (row >= ROW_W'(2)) && (col >= COL_W'(2));
      tag0       <= t && row_last && col_last;
      v1         <= v0;
      tag1       <= tag0;
      out_valid  <= v1;
      out_data   <= v1 ? ELEMENT_WIDTH'(total >> NORM_SHIFT) : '0;
      frame_done <= tag1;
      // An accept wins over frame_done so back-to-back frames stay busy.
      if (t)               busy <= 1'b1;
      else if (frame_done) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stencil3x3_avg.sv
// tb/tb_stencil3x3_avg.sv - self-checking bench for stencil3x3_avg
module tb_stencil3x3_avg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        t;
  logic [31:0] in_data;
  logic        out_valid;
  logic [31:0] out_data;
  logic        frame_done;
  logic        busy;

  logic        t6;
  logic [31:0] in6;
  logic        ov6;
  logic [31:0] od6;
  logic        fd6;
  logic        busy6;

  stencil3x3_avg #(.ELEMENT_WIDTH(32), .ROW_LEN(4), .NUM_ROWS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .t          (t),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .frame_done (frame_done),
    .busy       (busy)
  );

  stencil3x3_avg #(.ELEMENT_WIDTH(32), .ROW_LEN(5), .NUM_ROWS(3)) dut6 (
    .clk        (clk),
    .rst        (rst),
    .t          (t6),
    .in_data    (in6),
    .out_valid  (ov6),
    .out_data   (od6),
    .frame_done (fd6),
    .busy       (busy6)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] cap_val[$];
  int          cap_cyc[$];
  logic        cap_fd[$];
  logic        cap_busy[$];
  logic [31:0] c6_val[$];
  logic        c6_fd[$];
  int          idle_nz = 0;
  int          fd_stray = 0;
  int          acc_cyc[64];

  always @(negedge clk) begin
    if (out_valid) begin
      cap_val.push_back(out_data);
      cap_cyc.push_back(cyc);
      cap_fd.push_back(frame_done);
      cap_busy.push_back(busy);
    end else begin
      if (out_data != 32'd0) idle_nz++;
      if (frame_done) fd_stray++;
    end
    if (ov6) begin
      c6_val.push_back(od6);
      c6_fd.push_back(fd6);
    end
  end

  typedef struct packed {
    logic [15:0][31:0] pix;
    logic [3:0][31:0]  exp;
    logic [1:0]        max_gap;
    logic              exact;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input logic [1:0] g, input logic ex);
    vec_t v;
    v.pix     = '0;
    v.exp[0]  = e0;
    v.exp[1]  = e1;
    v.exp[2]  = e2;
    v.exp[3]  = e3;
    v.max_gap = g;
    v.exact   = ex;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic clear_caps();
    cap_val.delete();
    cap_cyc.delete();
    cap_fd.delete();
    cap_busy.delete();
    c6_val.delete();
    c6_fd.delete();
  endtask

  task automatic drive_pixel(input logic [31:0] v, input int idx);
    @(negedge clk);
    t = 1'b1;
    in_data = v;
    acc_cyc[idx] = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      t = 1'b0;
      in_data = '0;
    end
  endtask

  // Checks the captured outputs of one 4x4 frame against expected values.
  task automatic check_frame(input string tag, input int base,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3,
                             input int off, input logic exact);
    logic [31:0] ev[4];
    int trig[4];
    int rel[4];
    ev = '{e0, e1, e2, e3};
    trig = '{10, 11, 14, 15};
    rel = '{13, 14, 17, 18};
    for (int i = 0; i < 4; i++) begin
      if (off + i < cap_val.size()) begin
        check($sformatf("%s out%0d value", tag, i), cap_val[off+i], ev[i]);
        check($sformatf("%s out%0d latency", tag, i), cap_cyc[off+i] - acc_cyc[base+trig[i]], 3);
        check($sformatf("%s out%0d frame_done", tag, i), cap_fd[off+i], (i == 3));
        if (exact)
          check($sformatf("%s out%0d cycle", tag, i), cap_cyc[off+i] - acc_cyc[base], rel[i]);
        if (i == 3) check($sformatf("%s busy at frame_done", tag), cap_busy[off+i], 1);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    t = 1'b0;
    in_data = '0;
    t6 = 1'b0;
    in6 = '0;

    vecs[0] = mk(32'd16, 32'd16, 32'd16, 32'd16, 2'd0, 1'b1);
    vecs[1] = mk(32'd4, 32'd2, 32'd2, 32'd1, 2'd0, 1'b0);
    vecs[2] = mk(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 1'b0);
    vecs[3] = mk(32'd14, 32'd13, 32'd13, 32'd11, 2'd0, 1'b0);
    vecs[4] = mk(32'd16, 32'd16, 32'd16, 32'd16, 2'd3, 1'b0);
    vecs[5] = mk(32'd5, 32'd6, 32'd9, 32'd10, 2'd1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      vecs[0].pix[i] = 32'd16;
      vecs[1].pix[i] = (i == 5) ? 32'd16 : 32'd0;
      vecs[2].pix[i] = 32'hFFFF_FFFF;
      vecs[3].pix[i] = (i == 10) ? 32'd0 : 32'd15;
      vecs[4].pix[i] = 32'd16;
      vecs[5].pix[i] = 32'(i);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset frame_done", frame_done, 0);
    check("reset busy", busy, 0);
    rst = 1'b1;
    idle(3);

    // Table-driven frames
    for (int vi = 0; vi < 6; vi++) begin
      clear_caps();
      for (int i = 0; i < 16; i++) begin
        drive_pixel(vecs[vi].pix[i], i);
        idle($urandom_range(0, int'(vecs[vi].max_gap)));
      end
      idle(10);
      check($sformatf("vec%0d output count", vi), cap_val.size(), 4);
      check_frame($sformatf("vec%0d", vi), 0, vecs[vi].exp[0], vecs[vi].exp[1],
                  vecs[vi].exp[2], vecs[vi].exp[3], 0, vecs[vi].exact);
      check($sformatf("vec%0d busy after", vi), busy, 0);
    end

    // Reset mid-frame (after 6 pixels, and with an output in flight after 11)
    for (int k = 0; k < 2; k++) begin
      int n;
      n = (k == 0) ? 6 : 11;
      clear_caps();
      for (int i = 0; i < n; i++) drive_pixel(32'd100 + 32'(i), i);
      @(negedge clk);
      t = 1'b0;
      rst = 1'b0;
      #1;
      check($sformatf("midreset%0d out_valid", k), out_valid, 0);
      check($sformatf("midreset%0d busy", k), busy, 0);
      check($sformatf("midreset%0d out_data", k), out_data, 0);
      idle(2);
      // t is ignored during the two synchroniser edges after release
      @(negedge clk);
      rst = 1'b1;
      t = 1'b1;
      in_data = 32'hDEAD_BEEF;
      @(negedge clk);
      t = 1'b1;
      in_data = 32'hDEAD_BEEF;
      for (int i = 0; i < 16; i++) drive_pixel(32'(i), i);
      idle(10);
      check($sformatf("midreset%0d output count", k), cap_val.size(), 4);
      check_frame($sformatf("midreset%0d", k), 0, 32'd5, 32'd6, 32'd9, 32'd10, 0, 1'b1);
    end

    // Two back-to-back frames
    clear_caps();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 16; i++) drive_pixel(32'(i + f), f * 16 + i);
    idle(10);
    check("b2b output count", cap_val.size(), 8);
    check_frame("b2b f0", 0, 32'd5, 32'd6, 32'd9, 32'd10, 0, 1'b1);
    check_frame("b2b f1", 16, 32'd6, 32'd7, 32'd10, 32'd11, 4, 1'b1);
    check("b2b busy after", busy, 0);

    // ROW_LEN=5, NUM_ROWS=3 ramp
    clear_caps();
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      t6 = 1'b1;
      in6 = 32'(i);
    end
    @(negedge clk);
    t6 = 1'b0;
    in6 = '0;
    repeat (8) @(negedge clk);
    check("r5x3 output count", c6_val.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < c6_val.size()) begin
        check($sformatf("r5x3 out%0d value", i), c6_val[i], 32'd6 + 32'(i));
        check($sformatf("r5x3 out%0d frame_done", i), c6_fd[i], (i == 2));
      end
    end
    check("r5x3 busy after", busy6, 0);

    check("idle out_data zero", idle_nz, 0);
    check("stray frame_done", fd_stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
